mbist_comparator_diag: RTL and testbench

- Parametrised multi-channel MBIST comparator that replaces the single-channel write-first comparator.
- Fully synchronous to comp_clk: captures expected data, compares read data under a bit mask, and tracks sticky fail status per channel plus a saturating fail count.
- Records failing addresses in a FIFO fail log that the MBIST controller or the diagnostic readout reads.
- Sits between the MBIST controller/pattern generator and the memory-under-test read port.

---
 rtl/mbist_cmp_pkg.sv | 17 +
 rtl/mbist_fail_log.sv | 74 +++++++
 rtl/mbist_comparator_diag.sv | 166 ++++++++++++++++
 tb/tb_mbist_comparator_diag.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mbist_cmp_pkg.sv
// Shared types for the multi-channel MBIST comparator.
// State encoding and fail-log entry sizing.
package mbist_cmp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2,
        DONE = 2'd3
    } state_e;

    // A log entry is {address, failing-channel bitmap}.
    function automatic int log_w(input int aw, input int nch);
        return aw + nch;
    endfunction

endpackage

// File: rtl/mbist_fail_log.sv
// Fail-address log: synchronous FIFO with sticky overflow.
// Head entry is presented combinationally.
module mbist_fail_log #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty,
    output logic         overflow
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_q;
    logic [PW-1:0] rd_q;
    logic [PW:0]   cnt_q;
    logic          ovf_q;
    logic          do_pop;
    logic          do_push;

    assign empty    = (cnt_q == '0);
    assign full     = (cnt_q == FULL_CNT);
    assign overflow = ovf_q;
    assign dout     = mem_q[rd_q];

    // A pop frees a slot in the same cycle, so push+pop when full is legal.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else if (clr) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            if (do_push) begin
                wr_q <= wr_q + 1'b1;
            end
            if (do_pop) begin
                rd_q <= rd_q + 1'b1;
            end
            if (do_push && !do_pop) begin
                cnt_q <= cnt_q + 1'b1;
            end else if (!do_push && do_pop) begin
                cnt_q <= cnt_q - 1'b1;
            end
            if (push && !do_push) begin
                ovf_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_q] <= din;
        end
    end

endmodule

// File: rtl/mbist_comparator_diag.sv
// Multi-channel MBIST comparator with sticky per-channel fail,
// saturating fail count, fail-address log and halt-on-fail.
module mbist_comparator_diag
    import mbist_cmp_pkg::*;
#(
    parameter int DW        = 8,
    parameter int AW        = 10,
    parameter int NCH       = 2,
    parameter int LOG_DEPTH = 4,
    parameter int CNT_W     = 16
) (
    input  logic              comp_clk,
    input  logic              reset,
    input  logic              comp_en,
    input  logic              clear,
    input  logic              capture,
    input  logic              check,
    input  logic              comp_alg_end,
    input  logic              stop_on_fail,
    input  logic              resume,
    input  logic [AW-1:0]     addr_in,
    input  logic [NCH*DW-1:0] data_in,
    input  logic [NCH*DW-1:0] data_out,
    input  logic [DW-1:0]     cmp_mask,
    input  logic              log_rd,
    output logic [AW-1:0]     log_addr,
    output logic [NCH-1:0]    log_map,
    output logic              log_valid,
    output logic              log_overflow,
    output logic [NCH-1:0]    fail,
    output logic              fail_any,
    output logic [CNT_W-1:0]  fail_cnt,
    output logic              halt,
    output logic              done
);

    localparam int LW = log_w(AW, NCH);

    state_e              state_q;
    logic [NCH*DW-1:0]   exp_q;
    logic [AW-1:0]       exp_addr_q;
    logic                s1_v_q;
    logic [NCH-1:0]      s1_map_q;
    logic [AW-1:0]       s1_addr_q;
    logic                alg1_q;
    logic                alg2_q;
    logic [NCH-1:0]      fail_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                done_q;
    logic [NCH-1:0]      mis_d;
    logic                active;
    logic                commit_fail;
    logic [LW-1:0]       log_head;
    logic                log_empty;
    logic                log_full_unused;

    assign active      = comp_en && (state_q == RUN);
    assign commit_fail = s1_v_q && (|s1_map_q);

    always_comb begin
        mis_d = '0;
        for (int k = 0; k < NCH; k++) begin
            mis_d[k] = |((exp_q[k*DW +: DW] ^ data_out[k*DW +: DW]) & cmp_mask);
        end
    end

    always_ff @(posedge comp_clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            exp_q      <= '0;
            exp_addr_q <= '0;
            s1_v_q     <= 1'b0;
            s1_map_q   <= '0;
            s1_addr_q  <= '0;
            alg1_q     <= 1'b0;
            alg2_q     <= 1'b0;
            fail_q     <= '0;
            cnt_q      <= '0;
            done_q     <= 1'b0;
        end else if (clear) begin
            state_q    <= IDLE;
            exp_q      <= '0;
            exp_addr_q <= '0;
            s1_v_q     <= 1'b0;
            s1_map_q   <= '0;
            s1_addr_q  <= '0;
            alg1_q     <= 1'b0;
            alg2_q     <= 1'b0;
            fail_q     <= '0;
            cnt_q      <= '0;
            done_q     <= 1'b0;
        end else begin
            // Stage 1 samples the old expected value before any capture.
            s1_v_q    <= active && check;
            s1_map_q  <= mis_d;
            s1_addr_q <= exp_addr_q;
            if (active && capture) begin
                exp_q      <= data_in;
                exp_addr_q <= addr_in;
            end
            alg1_q <= comp_alg_end && comp_en
                      && (state_q == RUN || state_q == HALT);
            alg2_q <= alg1_q;
            if (commit_fail) begin
                fail_q <= fail_q | s1_map_q;
                if (~&cnt_q) begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
            unique case (state_q)
                IDLE: begin
                    if (comp_en) state_q <= RUN;
                end
                RUN: begin
                    if (!comp_en) begin
                        state_q <= IDLE;
                    end else if (alg2_q) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end else if (commit_fail && stop_on_fail) begin
                        state_q <= HALT;
                    end
                end
                HALT: begin
                    if (!comp_en) begin
                        state_q <= IDLE;
                    end else if (alg2_q) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end else if (resume) begin
                        state_q <= RUN;
                    end
                end
                DONE: begin
                    state_q <= DONE;
                end
            endcase
        end
    end

    mbist_fail_log #(
        .W     (LW),
        .DEPTH (LOG_DEPTH)
    ) u_log (
        .clk      (comp_clk),
        .rst      (reset),
        .clr      (clear),
        .push     (commit_fail),
        .pop      (log_rd),
        .din      ({s1_addr_q, s1_map_q}),
        .dout     (log_head),
        .full     (log_full_unused),
        .empty    (log_empty),
        .overflow (log_overflow)
    );

    assign log_addr  = log_head[LW-1:NCH];
    assign log_map   = log_head[NCH-1:0];
    assign log_valid = !log_empty;
    assign fail      = fail_q;
    assign fail_any  = |fail_q;
    assign fail_cnt  = cnt_q;
    assign halt      = (state_q == HALT);
    assign done      = done_q;

endmodule

// File: tb/tb_mbist_comparator_diag.sv
// Scoreboard bench for mbist_comparator_diag: directed
// boundary cases plus a randomized run against a reference model.
module tb_mbist_comparator_diag;

    localparam int DW  = 8;
    localparam int AW  = 4;
    localparam int NCH = 2;
    localparam int LD  = 4;
    localparam int CW  = 16;

    logic              comp_clk = 1'b0;
    logic              reset;
    logic              comp_en;
    logic              clear;
    logic              capture;
    logic              check;
    logic              comp_alg_end;
    logic              stop_on_fail;
    logic              resume;
    logic [AW-1:0]     addr_in;
    logic [NCH*DW-1:0] data_in;
    logic [NCH*DW-1:0] data_out;
    logic [DW-1:0]     cmp_mask;
    logic              log_rd;
    logic [AW-1:0]     log_addr;
    logic [NCH-1:0]    log_map;
    logic              log_valid;
    logic              log_overflow;
    logic [NCH-1:0]    fail;
    logic              fail_any;
    logic [CW-1:0]     fail_cnt;
    logic              halt;
    logic              done;

    logic mon_rd = 1'b0;
    logic dir_rd = 1'b0;
    logic drain_en = 1'b0;
    assign log_rd = mon_rd | dir_rd;

    int total = 0;
    int bad = 0;

    logic [AW+NCH-1:0] sb_q[$];

    mbist_comparator_diag #(
        .DW(DW), .AW(AW), .NCH(NCH), .LOG_DEPTH(LD), .CNT_W(CW)
    ) dut (
        .comp_clk(comp_clk), .reset(reset), .comp_en(comp_en),
        .clear(clear), .capture(capture), .check(check),
        .comp_alg_end(comp_alg_end), .stop_on_fail(stop_on_fail),
        .resume(resume), .addr_in(addr_in), .data_in(data_in),
        .data_out(data_out), .cmp_mask(cmp_mask), .log_rd(log_rd),
        .log_addr(log_addr), .log_map(log_map), .log_valid(log_valid),
        .log_overflow(log_overflow), .fail(fail), .fail_any(fail_any),
        .fail_cnt(fail_cnt), .halt(halt), .done(done)
    );

    always #5 comp_clk = ~comp_clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge comp_clk);
        #1;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        tick();
    endtask

    task automatic cap(input logic [AW-1:0] a, input logic [15:0] d);
        capture = 1'b1;
        addr_in = a;
        data_in = d;
        tick();
        capture = 1'b0;
    endtask

    task automatic chkrd(input logic [15:0] d);
        check = 1'b1;
        data_out = d;
        tick();
        check = 1'b0;
    endtask

    task automatic pop1();
        dir_rd = 1'b1;
        tick();
        dir_rd = 1'b0;
    endtask

    task automatic all_zero(input string tag);
        chk({tag, "_fail"}, 32'(fail), 0);
        chk({tag, "_fail_any"}, 32'(fail_any), 0);
        chk({tag, "_cnt"}, 32'(fail_cnt), 0);
        chk({tag, "_halt"}, 32'(halt), 0);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_log_valid"}, 32'(log_valid), 0);
        chk({tag, "_ovf"}, 32'(log_overflow), 0);
    endtask

    // Scoreboard monitor: drains the log and compares every head entry.
    always @(negedge comp_clk) begin
        logic [AW+NCH-1:0] e;
        mon_rd = 1'b0;
        if (drain_en && log_valid) begin
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_unexpected: got %0h/%0h want none",
                         log_addr, log_map);
            end else begin
                e = sb_q.pop_front();
                chk("sb_log_addr", 32'(log_addr), 32'(e[AW+NCH-1:NCH]));
                chk("sb_log_map", 32'(log_map), 32'(e[NCH-1:0]));
            end
            mon_rd = 1'b1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        logic [15:0] exp_m;
        logic [AW-1:0] ea_m;
        logic [NCH-1:0] fail_m;
        int cnt_m;
        logic [NCH-1:0] m;

        reset = 1'b1; comp_en = 1'b0; clear = 1'b0; capture = 1'b0;
        check = 1'b0; comp_alg_end = 1'b0; stop_on_fail = 1'b0;
        resume = 1'b0; addr_in = '0; data_in = '0; data_out = '0;
        cmp_mask = 8'hFF;
        tick();
        tick();
        all_zero("reset");
        reset = 1'b0;
        comp_en = 1'b1;
        tick();

        // Pass run ending in done.
        cap(4'd3, 16'hA5A5);
        chkrd(16'hA5A5);
        comp_alg_end = 1'b1;
        tick();
        comp_alg_end = 1'b0;
        tick();
        chk("pass_done_early", 32'(done), 0);
        tick();
        chk("pass_done", 32'(done), 1);
        chk("pass_fail", 32'(fail), 0);
        chk("pass_cnt", 32'(fail_cnt), 0);
        chk("pass_log_valid", 32'(log_valid), 0);
        comp_en = 1'b0;
        tick();
        chk("done_holds", 32'(done), 1);
        comp_en = 1'b1;
        do_clear();
        all_zero("clear");

        // Single fail on channel 1.
        cap(4'd3, 16'h3C3C);
        chkrd(16'h3D3C);
        chk("single_early", 32'(fail), 0);
        tick();
        chk("single_fail", 32'(fail), 2);
        chk("single_any", 32'(fail_any), 1);
        chk("single_cnt", 32'(fail_cnt), 1);
        chk("single_log_addr", 32'(log_addr), 3);
        chk("single_log_map", 32'(log_map), 2);

        // Masked-off bit does not fail.
        do_clear();
        cmp_mask = 8'hFE;
        cap(4'd3, 16'h3C3C);
        chkrd(16'h3D3C);
        tick();
        chk("mask_fail", 32'(fail), 0);
        chk("mask_cnt", 32'(fail_cnt), 0);
        chk("mask_log_valid", 32'(log_valid), 0);
        cmp_mask = 8'hFF;

        // Overflow: five fails, four slots.
        do_clear();
        for (int k = 0; k < 5; k++) begin
            cap(AW'(k), 16'h0000);
            chkrd(16'hFFFF);
        end
        tick();
        chk("ovf_cnt", 32'(fail_cnt), 5);
        chk("ovf_flag", 32'(log_overflow), 1);
        chk("ovf_head", 32'(log_addr), 0);
        chk("ovf_map", 32'(log_map), 3);
        for (int k = 1; k < 4; k++) begin
            pop1();
            chk("ovf_pop_addr", 32'(log_addr), 32'(k));
        end
        pop1();
        chk("ovf_empty", 32'(log_valid), 0);
        pop1();
        chk("pop_empty_ignored", 32'(log_valid), 0);
        cap(4'd9, 16'h0000);
        chkrd(16'h0001);
        tick();
        chk("after_empty_pop_head", 32'(log_addr), 9);

        // Push and pop together while full.
        do_clear();
        for (int k = 0; k < 4; k++) begin
            cap(AW'(k), 16'h0000);
            chkrd(16'hFFFF);
        end
        tick();
        chk("full_no_ovf", 32'(log_overflow), 0);
        cap(4'd4, 16'h0000);
        check = 1'b1;
        data_out = 16'hFFFF;
        tick();
        check = 1'b0;
        pop1();
        chk("pushpop_ovf", 32'(log_overflow), 0);
        chk("pushpop_head", 32'(log_addr), 1);
        chk("pushpop_cnt", 32'(fail_cnt), 5);
        for (int k = 2; k < 5; k++) begin
            pop1();
            chk("pushpop_drain", 32'(log_addr), 32'(k));
        end

        // Halt on fail, ignore checks in HALT, resume.
        do_clear();
        stop_on_fail = 1'b1;
        cap(4'd6, 16'h0000);
        chkrd(16'h0100);
        tick();
        chk("halt_set", 32'(halt), 1);
        chk("halt_cnt", 32'(fail_cnt), 1);
        chk("halt_addr", 32'(log_addr), 6);
        chkrd(16'hFFFF);
        tick();
        tick();
        chk("halt_ignored", 32'(fail_cnt), 1);
        resume = 1'b1;
        tick();
        resume = 1'b0;
        chk("resume_run", 32'(halt), 0);
        chkrd(16'hFFFF);
        tick();
        chk("resume_cnt", 32'(fail_cnt), 2);
        chk("rehalt", 32'(halt), 1);
        stop_on_fail = 1'b0;

        // Async reset with a fail in flight.
        do_clear();
        cap(4'd2, 16'h0000);
        chkrd(16'hFFFF);
        tick();
        chkrd(16'hFFFF);
        #2;
        reset = 1'b1;
        #1;
        all_zero("async");
        #1;
        reset = 1'b0;
        repeat (3) tick();
        chk("async_no_commit", 32'(fail_cnt), 0);
        chk("async_no_log", 32'(log_valid), 0);

        // Randomized run against the reference model.
        do_clear();
        drain_en = 1'b1;
        exp_m = '0;
        ea_m = '0;
        fail_m = '0;
        cnt_m = 0;
        for (int i = 0; i < 400; i++) begin
            int r;
            capture = ($urandom_range(0, 2) == 0);
            check = 1'($urandom_range(0, 1));
            addr_in = AW'($urandom);
            data_in = 16'($urandom);
            cmp_mask = ($urandom_range(0, 3) != 0) ? 8'hFF : 8'($urandom);
            r = $urandom_range(0, 2);
            if (r == 0) data_out = exp_m;
            else if (r == 1) data_out = exp_m ^ (16'd1 << $urandom_range(0, 15));
            else data_out = 16'($urandom);
            if (check) begin
                m = '0;
                for (int c = 0; c < NCH; c++)
                    for (int b = 0; b < DW; b++)
                        if (cmp_mask[b] &&
                            exp_m[c*DW+b] != data_out[c*DW+b])
                            m[c] = 1'b1;
                if (m != 0) begin
                    sb_q.push_back({ea_m, m});
                    fail_m = fail_m | m;
                    cnt_m++;
                end
            end
            if (capture) begin
                exp_m = data_in;
                ea_m = addr_in;
            end
            tick();
        end
        capture = 1'b0;
        check = 1'b0;
        repeat (6) tick();
        chk("rand_fail", 32'(fail), 32'(fail_m));
        chk("rand_cnt", 32'(fail_cnt), 32'(cnt_m));
        chk("rand_sb_left", 32'(sb_q.size()), 0);
        chk("rand_log_valid", 32'(log_valid), 0);
        chk("rand_ovf", 32'(log_overflow), 0);
        drain_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
